// File: rtl/mips_imem_loader_if.sv
// rtl/mips_imem_loader_if.sv - program byte stream in, instruction memory write bus out
interface mips_imem_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    // master is the loader side, slave is the byte source / memory side
    modport master (
        input  in_data,
        input  in_valid,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output in_data,
        output in_valid,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/mips_imem_loader.sv
// rtl/mips_imem_loader.sv - loads a length-prefixed big-endian program into instruction memory
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum word after the program.
module mips_imem_loader #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    mips_imem_loader_if.master bus,
    output logic               core_reset,
    output logic               done,
    output logic               error
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        DATA = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        TRL  = 3'd3,
`endif
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t END_STATE = TRL;
`else
    localparam state_t END_STATE = DONE;
`endif
    localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH_WORDS);

    state_t      state;
    state_t      state_next;
    logic [1:0]  byte_cnt;
    logic [31:0] word_cnt;
    logic [15:0] n_words;
    logic [23:0] shift;
    logic        accept;
    logic        start;
    logic        byte_last;
    logic        last_word;
    logic [31:0] word_in;
    logic [15:0] hdr_n;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] csum;
`endif

    assign accept    = bus.in_valid & bus.in_ready;
    assign start     = load & ((state == IDLE) | (state == DONE) | (state == ERR));
    assign byte_last = (byte_cnt == 2'd3);
    // the byte on the bus completes the word/header together with the bytes already shifted in
    assign word_in   = {shift, bus.in_data};
    assign hdr_n     = {shift[7:0], bus.in_data};
    assign last_word = ((word_cnt + 32'd1) == {16'd0, n_words});

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (load) state_next = HDR;
            end
            HDR: begin
                if (accept && byte_cnt[0]) begin
                    if ({16'd0, hdr_n} > DEPTH_LIMIT) state_next = ERR;
                    else if (hdr_n == 16'd0)          state_next = END_STATE;
                    else                              state_next = DATA;
                end
            end
            DATA: begin
                if (accept && byte_last && last_word) state_next = END_STATE;
            end
`ifdef LOADER_CHECKSUM_EN
            TRL: begin
                if (accept && byte_last) state_next = (word_in == csum) ? DONE : ERR;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = 1'b0;
        core_reset   = 1'b1;
        done         = 1'b0;
        error        = 1'b0;
        case (state)
            HDR, DATA: bus.in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            TRL:       bus.in_ready = 1'b1;
`endif
            DONE: begin
                core_reset = 1'b0;
                done       = 1'b1;
            end
            ERR:       error = 1'b1;
            default: ;
        endcase
    end

    // write strobe is registered, so it lands one cycle after the 4th byte is accepted
    always_ff @(posedge clock) begin
        if (reset) begin
            byte_cnt      <= 2'd0;
            word_cnt      <= 32'd0;
            n_words       <= 16'd0;
            shift         <= 24'd0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= 32'd0;
            bus.mem_wdata <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
            csum          <= 32'd0;
`endif
        end else begin
            bus.mem_we <= 1'b0;
            if (start) begin
                byte_cnt <= 2'd0;
                word_cnt <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
                csum     <= 32'd0;
`endif
            end else if (accept) begin
                shift    <= word_in[23:0];
                byte_cnt <= byte_cnt + 2'd1;
                if (state == HDR && byte_cnt[0]) begin
                    n_words  <= hdr_n;
                    byte_cnt <= 2'd0;
                end
                if (state == DATA && byte_last) begin
                    bus.mem_we    <= 1'b1;
                    bus.mem_addr  <= {word_cnt[29:0], 2'b00};
                    bus.mem_wdata <= word_in;
                    word_cnt      <= word_cnt + 32'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum          <= csum ^ word_in;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_mips_imem_loader.sv
// tb/tb_mips_imem_loader.sv - scoreboard bench for mips_imem_loader (LOADER_CHECKSUM_EN optional)
module tb_mips_imem_loader;
    logic clock;
    logic reset;
    logic load;
    logic core_reset;
    logic done;
    logic error;

    mips_imem_loader_if bus();

    mips_imem_loader #(.DEPTH_WORDS(256)) dut (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .bus        (bus),
        .core_reset (core_reset),
        .done       (done),
        .error      (error)
    );

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_w;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (bus.mem_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%08h data=%08h, no write expected", bus.mem_addr, bus.mem_wdata);
            end else begin
                exp_w = exp_q.pop_front();
                if ({bus.mem_addr, bus.mem_wdata} !== exp_w) begin
                    errors++;
                    $display("FAIL mem_write: got addr=%08h data=%08h expected addr=%08h data=%08h",
                             bus.mem_addr, bus.mem_wdata, exp_w[63:32], exp_w[31:0]);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        bit took;
        int guard;
        took  = 1'b0;
        guard = 0;
        bus.in_data = b;
        while (!took) begin
            bus.in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clock);
            took = bus.in_valid && bus.in_ready;
            @(posedge clock);
            #1;
            guard++;
            if (!took && guard > 64) begin
                checks++;
                errors++;
                $display("FAIL byte_timeout: byte %02h not accepted within 64 cycles", b);
                took = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit rnd);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], rnd);
    endtask

    task automatic end_load(input logic [31:0] c);
`ifdef LOADER_CHECKSUM_EN
        send_word(c, 1'b0);
`else
        if (c === 32'hx) $display("checksum unused");
`endif
    endtask

    task automatic pulse_load();
        load = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clock);
        #1;
        load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({bus.in_ready, bus.mem_we, done, error, core_reset} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b",
                     {bus.in_ready, bus.mem_we, done, error, core_reset}, 5'b00001);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        pulse_load();
        exp_q.push_back({32'h0, 32'h20080005});
        exp_q.push_back({32'h4, 32'h00000000});
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_word(32'h20080005, 1'b0);
        send_word(32'h00000000, 1'b0);
        end_load(32'h20080005);
        @(negedge clock);
        checks++;
        if ({bus.in_ready, done, error, core_reset} !== 4'b0100) begin
            errors++;
            $display("FAIL basic_done: got %b expected %b", {bus.in_ready, done, error, core_reset}, 4'b0100);
        end
        repeat (3) @(negedge clock);
        checks++;
        if ({bus.in_ready, done, error, core_reset} !== 4'b0100) begin
            errors++;
            $display("FAIL basic_done_held: got %b expected %b", {bus.in_ready, done, error, core_reset}, 4'b0100);
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_writes: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_overflow();
        pulse_load();
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        @(negedge clock);
        checks++;
        if ({bus.in_ready, done, error, core_reset} !== 4'b0011) begin
            errors++;
            $display("FAIL overflow_error: got %b expected %b", {bus.in_ready, done, error, core_reset}, 4'b0011);
        end
        repeat (3) @(posedge clock);
        #1;
        // N equal to the capacity is legal and must enter DATA
        pulse_load();
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        @(negedge clock);
        checks++;
        if ({bus.in_ready, done, error, core_reset} !== 4'b1001) begin
            errors++;
            $display("FAIL depth_boundary: got %b expected %b", {bus.in_ready, done, error, core_reset}, 4'b1001);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_zero_words();
        pulse_load();
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        end_load(32'h0);
        @(negedge clock);
        checks++;
        if ({bus.in_ready, done, error, core_reset} !== 4'b0100) begin
            errors++;
            $display("FAIL zero_words_done: got %b expected %b", {bus.in_ready, done, error, core_reset}, 4'b0100);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset_mid_word();
        pulse_load();
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        reset = 1'b1;
        load  = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        load  = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clock);
        checks++;
        if ({bus.in_ready, done, error, core_reset} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_mid_idle: got %b expected %b", {bus.in_ready, done, error, core_reset}, 4'b0001);
        end
        repeat (4) @(posedge clock);
        #1;
        pulse_load();
        exp_q.push_back({32'h0, 32'hAABBCCDD});
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_word(32'hAABBCCDD, 1'b0);
        end_load(32'hAABBCCDD);
        @(negedge clock);
        checks++;
        if ({bus.in_ready, done, error, core_reset} !== 4'b0100) begin
            errors++;
            $display("FAIL reload_done: got %b expected %b", {bus.in_ready, done, error, core_reset}, 4'b0100);
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL reload_writes: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clock);
        #1;
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        for (int pass = 0; pass < 2; pass++) begin
            pulse_load();
            exp_q.push_back({32'h0, 32'h12345678});
            exp_q.push_back({32'h4, 32'h0F0F0F0F});
            send_byte(8'h00, 1'b0);
            send_byte(8'h02, 1'b0);
            send_word(32'h12345678, 1'b0);
            send_word(32'h0F0F0F0F, 1'b0);
            send_word(pass == 0 ? 32'h1D3B5977 : 32'h00000000, 1'b0);
            @(negedge clock);
            checks++;
            if ({bus.in_ready, done, error, core_reset} !== (pass == 0 ? 4'b0100 : 4'b0011)) begin
                errors++;
                $display("FAIL checksum_result_%0d: got %b expected %b", pass,
                         {bus.in_ready, done, error, core_reset}, (pass == 0 ? 4'b0100 : 4'b0011));
            end
            @(posedge clock);
            #1;
        end
    endtask
`endif

    task automatic test_random_valid();
        logic [31:0] w;
        logic [31:0] c;
        c = 32'h0;
        pulse_load();
        send_byte(8'h00, 1'b1);
        send_byte(8'h05, 1'b1);
        // load is asserted throughout DATA and must be ignored
        load = 1'b1;
        for (int k = 0; k < 5; k++) begin
            w = $urandom;
            c = c ^ w;
            exp_q.push_back({32'(4 * k), w});
            send_word(w, 1'b1);
        end
        load = 1'b0;
        end_load(c);
        @(negedge clock);
        checks++;
        if ({bus.in_ready, done, error, core_reset} !== 4'b0100) begin
            errors++;
            $display("FAIL random_valid_done: got %b expected %b", {bus.in_ready, done, error, core_reset}, 4'b0100);
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_valid_writes: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        load = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        test_reset();
        test_basic();
        test_overflow();
        test_zero_words();
        test_reset_mid_word();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_random_valid();
        repeat (2) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_imem_loader.md
MIPS_IMEM_LOADER -- requirements
Module: mips_imem_loader

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, the instruction memory capacity in 32-bit words.
REQ-002 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port load  input  1  start pulse that begins a new program load.
REQ-005 SHALL have port in_data  input  8  incoming program byte.
REQ-006 SHALL have port in_valid  input  1  in_data is valid.
REQ-007 SHALL have port in_ready  output  1  the loader accepts a byte this cycle.
REQ-008 SHALL have port mem_we  output  1  instruction memory write strobe.
REQ-009 SHALL have port mem_addr  output  32  byte address of the write, word aligned.
REQ-010 SHALL have port mem_wdata  output  32  instruction word to write.
REQ-011 SHALL have port core_reset  output  1  holds the program counter and core in reset.
REQ-012 SHALL have port done  output  1  load completed successfully.
REQ-013 SHALL have port error  output  1  load aborted.

Function
REQ-014 SHALL implement the states IDLE, HDR, DATA, TRL (present only with the macro), DONE and ERR.
REQ-015 SHALL accept a byte only when in_valid=1 and in_ready=1; in_ready SHALL be 1 exactly in states HDR, DATA and TRL.
REQ-016 SHALL move from IDLE, DONE or ERR to HDR when load=1, clearing done, error, the byte counter and the word counter.
REQ-017 SHALL ignore load while in HDR, DATA or TRL.
REQ-018 SHALL in HDR take two bytes, most significant first, forming word count N (16 bits).
REQ-019 SHALL go from HDR to ERR when N > DEPTH_WORDS, to DONE (or to TRL with the macro) when N = 0, and to DATA otherwise.
REQ-020 SHALL in DATA assemble 4 bytes big-endian (first byte to bits [31:24]) into word k, where k runs 0..N-1.
REQ-021 SHALL pulse mem_we for exactly one cycle, in the cycle after the 4th byte of word k is accepted, with mem_addr = 4*k and mem_wdata = the assembled word.
REQ-022 SHALL keep in_ready high during the mem_we cycle, so that back-to-back bytes are accepted with no stall.
REQ-023 SHALL leave DATA after word N-1 is written, going to TRL (with the macro) or to DONE.
REQ-024 SHALL hold mem_we=0 outside the write cycles; mem_addr and mem_wdata are don't-care when mem_we=0.
REQ-025 SHALL drive core_reset=1 in every state except DONE; core_reset SHALL fall in the same cycle that done rises.
REQ-026 SHALL hold done=1 only in DONE and error=1 only in ERR, each until the next load or reset.
REQ-027 SHALL compute the word counter and addresses modulo 2^32; with N <= DEPTH_WORDS no wrap-around occurs.

Reset
REQ-028 SHALL on reset=1 enter IDLE with core_reset=1 and in_ready, mem_we, done and error all 0.
REQ-029 SHALL on reset during HDR, DATA or TRL abandon the load, discard any partial word and issue no further mem_we; previously written words stay in memory.
REQ-030 SHALL give reset priority over load and in_valid in the same cycle.

Configuration
REQ-031 SHALL, when LOADER_CHECKSUM_EN is defined, keep a running XOR of every written word, then in TRL take a 4-byte big-endian trailer and go to DONE if the trailer equals the XOR, or to ERR otherwise.
REQ-032 SHALL, when LOADER_CHECKSUM_EN is not defined, omit the TRL state and the checksum logic; the load ends after word N-1 and no trailer bytes are consumed.

Verification
REQ-033 SHALL cover: reset, load pulse, bytes 00 02 | 20 08 00 05 | 00 00 00 00 with in_valid held high -> mem_we at addr 0x0 with 0x20080005, then at addr 0x4 with 0x00000000, then done=1 and core_reset=0 (without the macro).
REQ-034 SHALL cover: header 01 01 with DEPTH_WORDS=256 -> error=1 in the cycle after the second header byte, no mem_we, core_reset=1.
REQ-035 SHALL cover: header 00 00 -> done=1 with no mem_we (without the macro).
REQ-036 SHALL cover: reset asserted after 2 data bytes of word 0 -> IDLE, no mem_we; a following load with 00 01 AA BB CC DD -> one write of 0xAABBCCDD at addr 0x0.
REQ-037 SHALL cover: with LOADER_CHECKSUM_EN, words 0x12345678 and 0x0F0F0F0F followed by trailer 1D 3B 59 77 -> done=1; with trailer 00 00 00 00 -> error=1 and core_reset=1.
REQ-038 SHALL cover: in_valid toggled randomly during DATA -> bytes are taken only on in_valid & in_ready, and the written words are unchanged.
